approx_adder_err_monitor: RTL and testbench

- Sequential scoreboard on the result side of the approximate ripple-carry adders (nBitRcpa family).
- Consumes per-sample operands A/B plus the adder's {fn,sum} and computes the exact (N+1)-bit reference internally.
- Accumulates error metrics over a fixed window of SAMPLES accepted samples and reports them through a valid/ready result handshake.
- Replaces manual waveform comparison in adder characterisation runs.

---
 rtl/approx_adder_err_monitor.sv | 133 +++++++++++++
 tb/tb_approx_adder_err_monitor.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_monitor.sv
// Error scoreboard for approximate ripple-carry adders: accumulates error count, error-distance
// sum/max (and, with APPROX_MON_BITERR_EN, a per-bit error mask) over windows of SAMPLES samples.
module approx_adder_err_monitor #(
   parameter  int N       = 8,
   parameter  int SAMPLES = 16,
   localparam int CNT_W   = $clog2(SAMPLES + 1),
   localparam int SUM_W   = N + 1 + $clog2(SAMPLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic [N-1:0]     approx_sum,
   input  logic             approx_fn,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] err_count,
   output logic [SUM_W-1:0] ed_sum,
   output logic [N:0]       ed_max,
   output logic [N:0]       bit_err_mask
);

   typedef enum logic {ACCUM = 1'b0, REPORT = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] err_acc, err_nxt;
   logic [SUM_W-1:0] ed_acc, ed_nxt;
   logic [N:0]       max_acc, max_nxt;
   logic [N:0]       exact, approx, ed;
   logic             accept;

`ifdef APPROX_MON_BITERR_EN
   logic [N:0]       mask_acc, mask_nxt;
`endif

   assign accept = in_valid && in_ready;

   // Next-accumulator values include the sample at the inputs, so the final
   // sample of a window can be latched straight into the result registers.
   always_comb begin
      exact   = {1'b0, a} + {1'b0, b};
      approx  = {approx_fn, approx_sum};
      ed      = (exact >= approx) ? (exact - approx) : (approx - exact);
      err_nxt = err_acc + {{(CNT_W-1){1'b0}}, (ed != '0)};
      ed_nxt  = ed_acc + {{(SUM_W-N-1){1'b0}}, ed};
      max_nxt = (ed > max_acc) ? ed : max_acc;
`ifdef APPROX_MON_BITERR_EN
      mask_nxt = mask_acc | (exact ^ approx);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ACCUM;
         in_ready  <= 1'b1;
         res_valid <= 1'b0;
         cnt       <= '0;
         err_acc   <= '0;
         ed_acc    <= '0;
         max_acc   <= '0;
         err_count <= '0;
         ed_sum    <= '0;
         ed_max    <= '0;
`ifdef APPROX_MON_BITERR_EN
         mask_acc     <= '0;
         bit_err_mask <= '0;
`endif
      end else begin
         case (state)
            ACCUM: begin
               if (clear) begin
                  cnt     <= '0;
                  err_acc <= '0;
                  ed_acc  <= '0;
                  max_acc <= '0;
`ifdef APPROX_MON_BITERR_EN
                  mask_acc <= '0;
`endif
               end else if (accept) begin
                  if (cnt == LAST) begin
                     err_count <= err_nxt;
                     ed_sum    <= ed_nxt;
                     ed_max    <= max_nxt;
                     cnt       <= '0;
                     err_acc   <= '0;
                     ed_acc    <= '0;
                     max_acc   <= '0;
                     state     <= REPORT;
                     in_ready  <= 1'b0;
                     res_valid <= 1'b1;
`ifdef APPROX_MON_BITERR_EN
                     bit_err_mask <= mask_nxt;
                     mask_acc     <= '0;
`endif
                  end else begin
                     cnt     <= cnt + CNT_W'(1);
                     err_acc <= err_nxt;
                     ed_acc  <= ed_nxt;
                     max_acc <= max_nxt;
`ifdef APPROX_MON_BITERR_EN
                     mask_acc <= mask_nxt;
`endif
                  end
               end
            end
            REPORT: begin
               // clear is deliberately ignored here: pending results survive it.
               if (res_ready) begin
                  state     <= ACCUM;
                  in_ready  <= 1'b1;
                  res_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ACCUM;
               in_ready  <= 1'b1;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

`ifndef APPROX_MON_BITERR_EN
   assign bit_err_mask = '0;
`endif

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Bench for approx_adder_err_monitor (N=8, SAMPLES=4): directed scenarios plus random traffic,
// all checked against a window-level reference model built from queues of per-sample errors.
module tb_approx_adder_err_monitor;
   localparam int N     = 8;
   localparam int S     = 4;
   localparam int CNT_W = $clog2(S + 1);
   localparam int SUM_W = N + 1 + $clog2(S);
   localparam int VW    = 2 + CNT_W + SUM_W + 2 * (N + 1);
   localparam logic [VW-1:0] RST_V = {1'b1, {(VW-1){1'b0}}};

   logic             clk = 1'b0;
   logic             rst_n, clear, in_valid, in_ready, approx_fn, res_valid, res_ready;
   logic [N-1:0]     a, b, approx_sum;
   logic [CNT_W-1:0] err_count;
   logic [SUM_W-1:0] ed_sum;
   logic [N:0]       ed_max, bit_err_mask;

   int vecs = 0;
   int fails = 0;

   // reference model state
   bit m_report;
   int q_ed[$];
   int q_mask[$];
   int o_err, o_sum, o_max, o_mask;

   approx_adder_err_monitor #(.N(N), .SAMPLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .approx_sum(approx_sum), .approx_fn(approx_fn),
      .res_valid(res_valid), .res_ready(res_ready), .err_count(err_count),
      .ed_sum(ed_sum), .ed_max(ed_max), .bit_err_mask(bit_err_mask));

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] obs_v();
      return {in_ready, res_valid, err_count, ed_sum, ed_max, bit_err_mask};
   endfunction

   function automatic logic [VW-1:0] exp_v();
      logic [CNT_W-1:0] e_err;
      logic [SUM_W-1:0] e_sum;
      logic [N:0]       e_max, e_mask;
      e_err  = o_err[CNT_W-1:0];
      e_sum  = o_sum[SUM_W-1:0];
      e_max  = o_max[N:0];
      e_mask = o_mask[N:0];
      return {~m_report, m_report, e_err, e_sum, e_max, e_mask};
   endfunction

   task automatic drive(input bit v, input int aa, input int bb, input int ap);
      in_valid   = v;
      a          = aa[N-1:0];
      b          = bb[N-1:0];
      approx_sum = ap[N-1:0];
      approx_fn  = ap[N];
   endtask

   // Advance the model by one clock edge using the inputs currently applied, then clock the DUT.
   task automatic tick();
      int ex, ap, ed;
      ex = int'(a) + int'(b);
      ap = int'({approx_fn, approx_sum});
      ed = (ex > ap) ? ex - ap : ap - ex;
      if (!rst_n) begin
         m_report = 0;
         q_ed.delete(); q_mask.delete();
         o_err = 0; o_sum = 0; o_max = 0; o_mask = 0;
      end else if (!m_report) begin
         if (clear) begin
            q_ed.delete(); q_mask.delete();
         end else if (in_valid) begin
            q_ed.push_back(ed);
            q_mask.push_back(ex ^ ap);
            if (q_ed.size() == S) begin
               o_err = 0; o_sum = 0; o_max = 0; o_mask = 0;
               foreach (q_ed[i]) begin
                  if (q_ed[i] != 0) o_err++;
                  o_sum += q_ed[i];
                  if (q_ed[i] > o_max) o_max = q_ed[i];
`ifdef APPROX_MON_BITERR_EN
                  o_mask |= q_mask[i];
`endif
               end
               q_ed.delete(); q_mask.delete();
               m_report = 1;
            end
         end
      end else if (res_ready) begin
         m_report = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int aa, input int bb, input int ap);
      drive(1'b1, aa, bb, ap);
      tick();
      drive(1'b0, 0, 0, 0);
   endtask

   task automatic feed_rand();
      int aa, bb, ap;
      aa = int'($urandom_range(0, 255));
      bb = int'($urandom_range(0, 255));
      ap = ($urandom_range(0, 1) == 0) ? aa + bb : ((aa + bb) ^ int'($urandom_range(0, 511)));
      feed(aa, bb, ap);
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      drive(1'b0, 0, 0, 0);
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; res_ready = 1'b0;
      drive(1'b1, 7, 9, 0);
      tick();
      rst_n = 1'b1;
      drive(1'b0, 0, 0, 0);
      vecs++;
      if (obs_v() !== RST_V) begin
         fails++; $display("FAIL reset: got %h want %h", obs_v(), RST_V);
      end
   endtask

   task automatic test_window();
      int ta[4] = '{50, 81, 60, 103};
      int tb[4] = '{1, 18, 81, 97};
      int tp[4] = '{51, 97, 141, 192};
      logic [N:0] want_mask;
`ifdef APPROX_MON_BITERR_EN
      want_mask = 9'h00A;
`else
      want_mask = '0;
`endif
      for (int i = 0; i < 4; i++) begin
         feed(ta[i], tb[i], tp[i]);
         vecs++;
         if (obs_v() !== exp_v()) begin
            fails++; $display("FAIL window s%0d: got %h want %h", i, obs_v(), exp_v());
         end
      end
      vecs++;
      if ({res_valid, err_count, ed_sum, ed_max, bit_err_mask} !==
          {1'b1, 3'd2, 11'd10, 9'd8, want_mask}) begin
         fails++; $display("FAIL window_result: got v=%0d e=%0d s=%0d m=%0d k=%h",
                           res_valid, err_count, ed_sum, ed_max, bit_err_mask);
      end
      handshake();
      vecs++;
      if (obs_v() !== exp_v()) begin
         fails++; $display("FAIL window_hs: got %h want %h", obs_v(), exp_v());
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) feed(255, 255, 0);
      vecs++;
      if ({res_valid, err_count, ed_sum, ed_max} !== {1'b1, 3'd4, 11'd2040, 9'd510}) begin
         fails++; $display("FAIL overflow: got v=%0d e=%0d s=%0d m=%0d want 1/4/2040/510",
                           res_valid, err_count, ed_sum, ed_max);
      end
      vecs++;
      if (obs_v() !== exp_v()) begin
         fails++; $display("FAIL overflow_model: got %h want %h", obs_v(), exp_v());
      end
      handshake();
      for (int i = 0; i < 4; i++) feed(16, 56, 80);
      vecs++;
      if ({res_valid, err_count, ed_sum, ed_max} !== {1'b1, 3'd4, 11'd32, 9'd8}) begin
         fails++; $display("FAIL absval: got v=%0d e=%0d s=%0d m=%0d want 1/4/32/8",
                           res_valid, err_count, ed_sum, ed_max);
      end
      vecs++;
      if (obs_v() !== exp_v()) begin
         fails++; $display("FAIL absval_model: got %h want %h", obs_v(), exp_v());
      end
      handshake();
   endtask

   task automatic test_backpressure();
      logic [VW-1:0] snap;
      for (int i = 0; i < 4; i++) feed_rand();
      snap = obs_v();
      vecs++;
      if (snap !== exp_v()) begin
         fails++; $display("FAIL bp_fill: got %h want %h", snap, exp_v());
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 3);
         tick();
         vecs++;
         if (obs_v() !== snap || obs_v() !== exp_v()) begin
            fails++; $display("FAIL bp_hold c%0d: got %h want %h", i, obs_v(), snap);
         end
      end
      res_ready = 1'b1;
      drive(1'b1, 200, 100, 7);
      tick();
      res_ready = 1'b0;
      drive(1'b0, 0, 0, 0);
      vecs++;
      if ({in_ready, res_valid} !== 2'b10 || obs_v()[VW-3:0] !== snap[VW-3:0]) begin
         fails++; $display("FAIL bp_release: got %h want ready=1 valid=0 data %h", obs_v(), snap);
      end
      for (int i = 0; i < 4; i++) begin
         feed_rand();
         vecs++;
         if (obs_v() !== exp_v()) begin
            fails++; $display("FAIL bp_next s%0d: got %h want %h", i, obs_v(), exp_v());
         end
      end
      vecs++;
      if (res_valid !== 1'b1) begin
         fails++; $display("FAIL bp_fresh: res_valid got %0d want 1", res_valid);
      end
      handshake();
   endtask

   task automatic test_clear();
      feed(81, 18, 97);
      feed(103, 97, 192);
      clear = 1'b1;
      drive(1'b1, 103, 97, 192);
      tick();
      clear = 1'b0;
      for (int i = 0; i < 4; i++) feed(50, 1, 51);
      vecs++;
      if ({res_valid, err_count, ed_sum, ed_max, bit_err_mask} !== {1'b1, {(VW-2){1'b0}}}) begin
         fails++; $display("FAIL clear: got v=%0d e=%0d s=%0d m=%0d k=%h want 1/0/0/0/0",
                           res_valid, err_count, ed_sum, ed_max, bit_err_mask);
      end
      clear = 1'b1;
      drive(1'b0, 0, 0, 0);
      tick();
      clear = 1'b0;
      vecs++;
      if (obs_v() !== exp_v() || res_valid !== 1'b1) begin
         fails++; $display("FAIL clear_in_report: got %h want %h", obs_v(), exp_v());
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) feed(255, 255, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      vecs++;
      if (obs_v() !== RST_V) begin
         fails++; $display("FAIL reset_mid: got %h want %h", obs_v(), RST_V);
      end
      feed(50, 1, 51); feed(81, 18, 97); feed(60, 81, 141); feed(103, 97, 192);
      vecs++;
      if ({res_valid, err_count, ed_sum, ed_max} !== {1'b1, 3'd2, 11'd10, 9'd8}) begin
         fails++; $display("FAIL reset_mid_win: got v=%0d e=%0d s=%0d m=%0d want 1/2/10/8",
                           res_valid, err_count, ed_sum, ed_max);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      vecs++;
      if (obs_v() !== RST_V) begin
         fails++; $display("FAIL reset_report: got %h want %h", obs_v(), RST_V);
      end
      for (int i = 0; i < 4; i++) feed(16, 56, 80);
      vecs++;
      if ({res_valid, err_count, ed_sum, ed_max} !== {1'b1, 3'd4, 11'd32, 9'd8}) begin
         fails++; $display("FAIL reset_report_win: got v=%0d e=%0d s=%0d m=%0d want 1/4/32/8",
                           res_valid, err_count, ed_sum, ed_max);
      end
      handshake();
   endtask

   task automatic test_idle_gaps();
      int ta[4] = '{50, 81, 60, 103};
      int tb[4] = '{1, 18, 81, 97};
      int tp[4] = '{51, 97, 141, 192};
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) feed(ta[i/2], tb[i/2], tp[i/2]);
         else begin
            drive(1'b0, 255, 255, 0);
            tick();
         end
         vecs++;
         if (obs_v() !== exp_v()) begin
            fails++; $display("FAIL idle c%0d: got %h want %h", i, obs_v(), exp_v());
         end
      end
      vecs++;
      if ({res_valid, err_count, ed_sum, ed_max} !== {1'b1, 3'd2, 11'd10, 9'd8}) begin
         fails++; $display("FAIL idle_result: got v=%0d e=%0d s=%0d m=%0d want 1/2/10/8",
                           res_valid, err_count, ed_sum, ed_max);
      end
      handshake();
   endtask

   task automatic test_random();
      int aa, bb, ap;
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 80) != 0);
         clear     = ($urandom_range(0, 15) == 0);
         res_ready = ($urandom_range(0, 2) == 0);
         aa = int'($urandom_range(0, 255));
         bb = int'($urandom_range(0, 255));
         case ($urandom_range(0, 3))
            0, 1:    ap = aa + bb;
            2:       ap = (aa + bb) ^ int'($urandom_range(0, 15));
            default: ap = int'($urandom_range(0, 511));
         endcase
         drive($urandom_range(0, 3) != 0, aa, bb, ap);
         tick();
         vecs++;
         if (obs_v() !== exp_v()) begin
            fails++; $display("FAIL random c%0d: got %h want %h", i, obs_v(), exp_v());
         end
      end
      rst_n = 1'b1; clear = 1'b0; res_ready = 1'b0;
      drive(1'b0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_window();
      test_overflow();
      test_backpressure();
      test_clear();
      test_reset_mid();
      test_idle_gaps();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
